// File: rtl/cart_pac_pkg.sv
// Shared definitions for the FM-PAC-class cartridge mapper: register offsets
// within the 16 KB cartridge page, the enable-register mask, and the OPLL
// write-queue entry layout.
package cart_pac_pkg;

   localparam logic [13:0] REG_MAGIC_LO = 14'h1FFE;
   localparam logic [13:0] REG_MAGIC_HI = 14'h1FFF;
   localparam logic [13:0] REG_OPLL_A   = 14'h3FF4;
   localparam logic [13:0] REG_OPLL_D   = 14'h3FF5;
   localparam logic [13:0] REG_ENABLE   = 14'h3FF6;
   localparam logic [13:0] REG_BANK     = 14'h3FF7;

   // Only bit 0 (OPLL enable) and bit 4 (SRAM lock) of the enable register exist.
   localparam logic [7:0]  ENABLE_MASK  = 8'h11;

   // Upper seven bits of the OPLL I/O port pair 7Ch/7Dh.
   localparam logic [6:0]  IO_PORT_HI   = 7'b0111110;

   // One pending OPLL bus write: a = A0 (0 = register address, 1 = data).
   typedef struct packed {
      logic       a;
      logic [7:0] d;
   } wq_entry_t;

endpackage

// File: rtl/cart_pac_wrq.sv
// OPLL write queue with recovery-time pacer. Entries are popped one at a time
// when the pacer has run out and a clk_en tick arrives; each pop produces a
// one-cycle opll_we with registered A0/data, then reloads the pacer with the
// recovery time that matches the kind of write just issued.
module cart_pac_wrq
   import cart_pac_pkg::*;
#(
   parameter int WQ_DEPTH = 8,
   parameter int ADDR_GAP = 12,
   parameter int DATA_GAP = 84
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clk_en_i,
   input  logic                      push_i,
   input  wq_entry_t                 entry_i,
   output logic                      opll_we_o,
   output logic                      opll_a_o,
   output logic [7:0]                opll_d_o,
   output logic [$clog2(WQ_DEPTH):0] level_o,
   output logic                      ovf_o
);

   localparam int PW      = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
   localparam int LW      = $clog2(WQ_DEPTH) + 1;
   localparam int GAP_MAX = (ADDR_GAP > DATA_GAP) ? ADDR_GAP : DATA_GAP;
   localparam int CW      = $clog2(GAP_MAX + 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(WQ_DEPTH);

   wq_entry_t     fifo_q [WQ_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [CW-1:0] pacer_q, pacer_d;
   logic          ovf_q, ovf_d;
   logic          we_q;
   logic          a_q;
   logic [7:0]    d_q;

   wq_entry_t     head;
   logic          full;
   logic          pop;
   logic          accept;

   assign head   = fifo_q[rd_ptr_q];
   assign full   = (level_q == FULL_LVL);
   assign pop    = (pacer_q == '0) && clk_en_i && (level_q != '0);
   // A pop in the same cycle frees the slot, so a push into a full queue survives.
   assign accept = push_i && (!full || pop);

   // Next-state for pointers, occupancy, overflow flag and pacer.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q + LW'(accept) - LW'(pop);
      ovf_d    = ovf_q;
      pacer_d  = pacer_q;
      if (pop)
         rd_ptr_d = rd_ptr_q + PW'(1);
      if (accept)
         wr_ptr_d = wr_ptr_q + PW'(1);
      if (push_i && !accept)
         ovf_d = 1'b1;
      if (pop)
         pacer_d = head.a ? CW'(DATA_GAP) : CW'(ADDR_GAP);
      else if (clk_en_i && (pacer_q != '0))
         pacer_d = pacer_q - CW'(1);
   end

   // Control state; reset flushes the queue and drops any pending strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         pacer_q  <= '0;
         we_q     <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         pacer_q  <= pacer_d;
         we_q     <= pop;
      end
   end

   // Queue storage and the output data register; contents are don't-care until qualified.
   always_ff @(posedge clk) begin
      if (accept)
         fifo_q[wr_ptr_q] <= entry_i;
      if (pop) begin
         a_q <= head.a;
         d_q <= head.d;
      end
   end

   assign opll_we_o = we_q;
   assign opll_a_o  = a_q;
   assign opll_d_o  = d_q;
   assign level_o   = level_q;
   assign ovf_o     = ovf_q;

endmodule

// File: rtl/cart_pac_mapper.sv
// FM-PAC-class cartridge mapper: ROM bank register, magic-unlocked battery
// SRAM window, and a paced OPLL write queue (cart_pac_wrq).
// Build option: define CART_PAC_IO_PORT_EN to also accept OPLL writes on
// I/O ports 7Ch/7Dh; without it only the memory-mapped registers push.
module cart_pac_mapper
   import cart_pac_pkg::*;
#(
   parameter int          BANK_BITS = 2,
   parameter int          SRAM_AW   = 13,
   parameter int          WQ_DEPTH  = 8,
   parameter int          ADDR_GAP  = 12,
   parameter int          DATA_GAP  = 84,
   parameter logic [15:0] MAGIC     = 16'h694D
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clk_en,
   input  logic [15:0]               addr,
   input  logic [7:0]                d_from_cpu,
   output logic [7:0]                d_to_cpu,
   input  logic                      cs,
   input  logic                      wr,
   input  logic                      rd,
   input  logic                      iorq,
   input  logic                      m1,
   output logic                      cart_oe,
   output logic                      sram_oe,
   output logic                      sram_we,
   output logic [SRAM_AW-1:0]        sram_addr,
   output logic [BANK_BITS+13:0]     mem_addr,
   output logic                      mem_oe,
   output logic                      opll_we,
   output logic                      opll_a,
   output logic [7:0]                opll_d,
   output logic [$clog2(WQ_DEPTH):0] wq_level,
   output logic                      wq_ovf
);

   logic                 wr_q;
   logic [7:0]           enable_q, enable_d;
   logic [BANK_BITS-1:0] bank_q, bank_d;
   logic [15:0]          magic_q, magic_d;

   logic [13:0]          off;
   logic                 wr_ev;
   logic                 mem_ev;
   logic                 io_ev;
   logic                 unlocked;
   logic                 push;
   wq_entry_t            push_entry;
   logic [7:0]           bank_rd;
   logic                 unused_pins;

   assign off      = addr[13:0];
   // A write is acted on once, at the rising edge of the wr level.
   assign wr_ev    = wr & ~wr_q;
   assign mem_ev   = cs & wr_ev;
   assign unlocked = (magic_q == MAGIC);

`ifdef CART_PAC_IO_PORT_EN
   assign io_ev       = iorq & ~m1 & (addr[7:1] == IO_PORT_HI) & wr_ev;
   assign unused_pins = ^{rd, addr[15:14]};
`else
   assign io_ev       = 1'b0;
   assign unused_pins = ^{rd, addr[15:14], iorq, m1};
`endif

   assign push       = (mem_ev & ((off == REG_OPLL_A) | (off == REG_OPLL_D))) | io_ev;
   assign push_entry = '{a: addr[0], d: d_from_cpu};

   // Register-write decode; an SRAM-lock write clears the magic latch.
   always_comb begin
      enable_d = enable_q;
      bank_d   = bank_q;
      magic_d  = magic_q;
      if (mem_ev) begin
         case (off)
            REG_MAGIC_LO: if (!enable_q[4]) magic_d[7:0]  = d_from_cpu;
            REG_MAGIC_HI: if (!enable_q[4]) magic_d[15:8] = d_from_cpu;
            REG_ENABLE: begin
               enable_d = d_from_cpu & ENABLE_MASK;
               if (d_from_cpu[4])
                  magic_d = '0;
            end
            REG_BANK:     bank_d = d_from_cpu[BANK_BITS-1:0];
            default: ;
         endcase
      end
   end

   // Mapper control registers and the write-edge detector.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q     <= 1'b0;
         enable_q <= '0;
         bank_q   <= '0;
         magic_q  <= '0;
      end else begin
         wr_q     <= wr;
         enable_q <= enable_d;
         bank_q   <= bank_d;
         magic_q  <= magic_d;
      end
   end

   // Zero-extended bank value for read-back.
   always_comb begin
      bank_rd                = '0;
      bank_rd[BANK_BITS-1:0] = bank_q;
   end

   // Register read-back; magic bytes are only visible once the window is open.
   always_comb begin
      cart_oe  = 1'b0;
      d_to_cpu = 8'hFF;
      if (cs) begin
         case (off)
            REG_ENABLE: begin
               cart_oe  = 1'b1;
               d_to_cpu = enable_q;
            end
            REG_BANK: begin
               cart_oe  = 1'b1;
               d_to_cpu = bank_rd;
            end
            REG_MAGIC_LO: if (unlocked) begin
               cart_oe  = 1'b1;
               d_to_cpu = magic_q[7:0];
            end
            REG_MAGIC_HI: if (unlocked) begin
               cart_oe  = 1'b1;
               d_to_cpu = magic_q[15:8];
            end
            default: ;
         endcase
      end
   end

   // SRAM occupies the lower 8 KB of the page; upper address bits stay zero.
   always_comb begin
      sram_addr       = '0;
      sram_addr[12:0] = addr[12:0];
   end

   assign sram_oe  = cs & unlocked & ~addr[13];
   assign sram_we  = sram_oe & wr;
   assign mem_addr = {bank_q, off};
   assign mem_oe   = cs;

   cart_pac_wrq #(
      .WQ_DEPTH (WQ_DEPTH),
      .ADDR_GAP (ADDR_GAP),
      .DATA_GAP (DATA_GAP)
   ) u_wrq (
      .clk       (clk),
      .reset     (reset),
      .clk_en_i  (clk_en),
      .push_i    (push),
      .entry_i   (push_entry),
      .opll_we_o (opll_we),
      .opll_a_o  (opll_a),
      .opll_d_o  (opll_d),
      .level_o   (wq_level),
      .ovf_o     (wq_ovf)
   );

endmodule

// File: tb/tb_cart_pac_mapper.sv
// Bench for cart_pac_mapper: register/SRAM-window vector table, hand-written
// OPLL pacing, overflow and reset sequences, then randomized traffic checked
// every cycle against a queue-based reference model.
module tb_cart_pac_mapper;

   localparam int          BANK_BITS = 2;
   localparam int          SRAM_AW   = 13;
   localparam int          WQ_DEPTH  = 8;
   localparam int          ADDR_GAP  = 12;
   localparam int          DATA_GAP  = 84;
   localparam logic [15:0] MAGIC     = 16'h694D;
   localparam int          LW        = $clog2(WQ_DEPTH) + 1;

   logic                  clk;
   logic                  reset;
   logic                  clk_en;
   logic [15:0]           addr;
   logic [7:0]            d_from_cpu;
   logic [7:0]            d_to_cpu;
   logic                  cs, wr, rd, iorq, m1;
   logic                  cart_oe, sram_oe, sram_we;
   logic [SRAM_AW-1:0]    sram_addr;
   logic [BANK_BITS+13:0] mem_addr;
   logic                  mem_oe;
   logic                  opll_we, opll_a;
   logic [7:0]            opll_d;
   logic [LW-1:0]         wq_level;
   logic                  wq_ovf;

   cart_pac_mapper #(
      .BANK_BITS (BANK_BITS),
      .SRAM_AW   (SRAM_AW),
      .WQ_DEPTH  (WQ_DEPTH),
      .ADDR_GAP  (ADDR_GAP),
      .DATA_GAP  (DATA_GAP),
      .MAGIC     (MAGIC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_en     (clk_en),
      .addr       (addr),
      .d_from_cpu (d_from_cpu),
      .d_to_cpu   (d_to_cpu),
      .cs         (cs),
      .wr         (wr),
      .rd         (rd),
      .iorq       (iorq),
      .m1         (m1),
      .cart_oe    (cart_oe),
      .sram_oe    (sram_oe),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .mem_addr   (mem_addr),
      .mem_oe     (mem_oe),
      .opll_we    (opll_we),
      .opll_a     (opll_a),
      .opll_d     (opll_d),
      .wq_level   (wq_level),
      .wq_ovf     (wq_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0]           m_enable;
   logic [BANK_BITS-1:0] m_bank;
   logic [15:0]          m_magic;
   logic                 m_prevwr;
   logic [8:0]           mq[$];
   int                   m_wait;
   logic                 m_ovf;
   logic                 m_we;
   logic [8:0]           m_out;

   // Observed strobes, for the hand-written sequences
   int                   cyc;
   int                   we_cyc[$];
   logic [8:0]           we_log[$];

   typedef struct packed {
      logic        c;
      logic        w;
      logic [15:0] a;
      logic [7:0]  d;
      logic        oe;
      logic [7:0]  dout;
      logic        sram;
   } vec_t;

   localparam int NV = 25;
   vec_t vt [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_enable = '0;
      m_bank   = '0;
      m_magic  = '0;
      m_prevwr = 1'b0;
      mq.delete();
      m_wait   = 0;
      m_ovf    = 1'b0;
      m_we     = 1'b0;
   endtask

   task automatic model_edge(input bit c, input bit w, input logic [15:0] a,
                             input logic [7:0] d, input bit ce);
      bit ev, pop, mem_push, io_push;
      if (reset) begin
         model_reset();
         return;
      end
      ev       = w && !m_prevwr;
      m_prevwr = w;
      pop      = (m_wait == 0) && ce && (mq.size() > 0);
      m_we     = pop;
      if (pop) begin
         m_out  = mq.pop_front();
         m_wait = m_out[8] ? DATA_GAP : ADDR_GAP;
      end else if (ce && m_wait > 0) begin
         m_wait--;
      end
      mem_push = ev && c && (a[13:0] == 14'h3FF4 || a[13:0] == 14'h3FF5);
`ifdef CART_PAC_IO_PORT_EN
      io_push  = ev && iorq && !m1 && (a[7:0] == 8'h7C || a[7:0] == 8'h7D);
`else
      io_push  = 1'b0;
`endif
      if (mem_push || io_push) begin
         if (mq.size() < WQ_DEPTH) mq.push_back({a[0], d});
         else m_ovf = 1'b1;
      end
      if (ev && c) begin
         if (a[13:0] == 14'h1FFE && !m_enable[4]) m_magic[7:0]  = d;
         if (a[13:0] == 14'h1FFF && !m_enable[4]) m_magic[15:8] = d;
         if (a[13:0] == 14'h3FF6) begin
            m_enable = d & 8'h11;
            if (d[4]) m_magic = '0;
         end
         if (a[13:0] == 14'h3FF7) m_bank = d[BANK_BITS-1:0];
      end
   endtask

   task automatic check_comb();
      bit         unl, e_oe, e_sram;
      logic [7:0] e_d;
      unl  = (m_magic == MAGIC);
      e_oe = 1'b0;
      e_d  = 8'hFF;
      if (cs) begin
         if (addr[13:0] == 14'h3FF6) begin e_oe = 1'b1; e_d = m_enable; end
         if (addr[13:0] == 14'h3FF7) begin e_oe = 1'b1; e_d = 8'(m_bank); end
         if (addr[13:0] == 14'h1FFE && unl) begin e_oe = 1'b1; e_d = m_magic[7:0]; end
         if (addr[13:0] == 14'h1FFF && unl) begin e_oe = 1'b1; e_d = m_magic[15:8]; end
      end
      e_sram = cs && unl && !addr[13];
      chk("cart_oe", cart_oe, e_oe);
      chk("d_to_cpu", d_to_cpu, e_d);
      chk("sram_oe", sram_oe, e_sram);
      chk("sram_we", sram_we, e_sram && wr);
      chk("sram_addr", sram_addr, {3'b0, addr[12:0]} & 16'h1FFF);
      chk("mem_addr", mem_addr, {m_bank, addr[13:0]});
      chk("mem_oe", mem_oe, cs);
   endtask

   task automatic check_regs();
      chk("opll_we", opll_we, m_we);
      if (m_we) begin
         chk("opll_a", opll_a, m_out[8]);
         chk("opll_d", opll_d, m_out[7:0]);
      end
      chk("wq_level", wq_level, mq.size());
      chk("wq_ovf", wq_ovf, m_ovf);
      if (opll_we === 1'b1) begin
         we_cyc.push_back(cyc);
         we_log.push_back({opll_a, opll_d});
      end
   endtask

   // One clock: drive after negedge, check comb, clock, update model, check regs.
   task automatic step(input bit c, input bit w, input logic [15:0] a,
                       input logic [7:0] d, input bit ce);
      cs = c; wr = w; addr = a; d_from_cpu = d; clk_en = ce;
      #1;
      check_comb();
      @(posedge clk);
      model_edge(c, w, a, d, ce);
      cyc++;
      #1;
      check_regs();
      @(negedge clk);
   endtask

   task automatic wr_pulse(input logic [15:0] a, input logic [7:0] d, input bit ce);
      step(1'b1, 1'b1, a, d, ce);
      step(1'b1, 1'b0, a, d, ce);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      vt[0]  = '{1'b1, 1'b0, 16'h3FF6, 8'h00, 1'b1, 8'h00, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 16'h3FF7, 8'h00, 1'b1, 8'h00, 1'b0};
      vt[2]  = '{1'b1, 1'b0, 16'h1FFE, 8'h00, 1'b0, 8'hFF, 1'b0};
      vt[3]  = '{1'b1, 1'b1, 16'h1FFE, 8'h4D, 1'b0, 8'hFF, 1'b0};
      vt[4]  = '{1'b1, 1'b1, 16'h1FFF, 8'h69, 1'b0, 8'hFF, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hFF, 1'b1};
      vt[6]  = '{1'b1, 1'b0, 16'h1FFE, 8'h00, 1'b1, 8'h4D, 1'b1};
      vt[7]  = '{1'b1, 1'b0, 16'h1FFF, 8'h00, 1'b1, 8'h69, 1'b1};
      vt[8]  = '{1'b1, 1'b1, 16'h3FF6, 8'h10, 1'b1, 8'h00, 1'b0};
      vt[9]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hFF, 1'b0};
      vt[10] = '{1'b1, 1'b0, 16'h3FF6, 8'h00, 1'b1, 8'h10, 1'b0};
      vt[11] = '{1'b1, 1'b1, 16'h1FFE, 8'h4D, 1'b0, 8'hFF, 1'b0};
      vt[12] = '{1'b1, 1'b1, 16'h1FFF, 8'h69, 1'b0, 8'hFF, 1'b0};
      vt[13] = '{1'b1, 1'b0, 16'h1FFE, 8'h00, 1'b0, 8'hFF, 1'b0};
      vt[14] = '{1'b1, 1'b1, 16'h3FF6, 8'hFF, 1'b1, 8'h10, 1'b0};
      vt[15] = '{1'b1, 1'b0, 16'h3FF6, 8'h00, 1'b1, 8'h11, 1'b0};
      vt[16] = '{1'b1, 1'b1, 16'h3FF6, 8'h01, 1'b1, 8'h11, 1'b0};
      vt[17] = '{1'b1, 1'b1, 16'h1FFE, 8'h4D, 1'b0, 8'hFF, 1'b0};
      vt[18] = '{1'b1, 1'b1, 16'h1FFF, 8'h69, 1'b0, 8'hFF, 1'b0};
      vt[19] = '{1'b1, 1'b0, 16'h0ABC, 8'h00, 1'b0, 8'hFF, 1'b1};
      vt[20] = '{1'b1, 1'b0, 16'h2000, 8'h00, 1'b0, 8'hFF, 1'b0};
      vt[21] = '{1'b1, 1'b1, 16'h3FF7, 8'hFF, 1'b1, 8'h00, 1'b0};
      vt[22] = '{1'b1, 1'b0, 16'h3FF7, 8'h00, 1'b1, 8'h03, 1'b0};
      vt[23] = '{1'b1, 1'b0, 16'h4123, 8'h00, 1'b0, 8'hFF, 1'b1};
      vt[24] = '{1'b0, 1'b0, 16'h3FF6, 8'h00, 1'b0, 8'hFF, 1'b0};

      cyc = 0;
      reset = 1'b1; clk_en = 1'b0; addr = '0; d_from_cpu = '0;
      cs = 1'b0; wr = 1'b0; rd = 1'b0; iorq = 1'b0; m1 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();

      // Reset state
      #1;
      chk("rst_opll_we", opll_we, 1'b0);
      chk("rst_wq_level", wq_level, 0);
      chk("rst_wq_ovf", wq_ovf, 1'b0);
      chk("rst_cart_oe", cart_oe, 1'b0);
      chk("rst_d_to_cpu", d_to_cpu, 8'hFF);
      @(negedge clk);

      // Register / SRAM window vectors
      for (int i = 0; i < NV; i++) begin
         cs = vt[i].c; wr = vt[i].w; addr = vt[i].a; d_from_cpu = vt[i].d; clk_en = 1'b0;
         #1;
         chk($sformatf("vec%0d_cart_oe", i), cart_oe, vt[i].oe);
         chk($sformatf("vec%0d_d_to_cpu", i), d_to_cpu, vt[i].dout);
         chk($sformatf("vec%0d_sram_oe", i), sram_oe, vt[i].sram);
         step(vt[i].c, vt[i].w, vt[i].a, vt[i].d, 1'b0);
         if (vt[i].w) step(vt[i].c, 1'b0, vt[i].a, vt[i].d, 1'b0);
      end
      cs = 1'b1; wr = 1'b0; addr = 16'h4123;
      #1;
      chk("bank3_mem_addr", mem_addr, 16'hC123);
      step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

      // OPLL pacing: address write, data write, then another address write
      do_reset();
      we_cyc.delete(); we_log.delete();
      wr_pulse(16'h3FF4, 8'h20, 1'b1);
      wr_pulse(16'h3FF5, 8'h1F, 1'b1);
      wr_pulse(16'h3FF4, 8'h07, 1'b1);
      for (int i = 0; i < 400 && we_cyc.size() < 3; i++)
         step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
      chk("pace_pulses", we_cyc.size(), 3);
      if (we_cyc.size() == 3) begin
         chk("pace_first", we_log[0], {1'b0, 8'h20});
         chk("pace_second", we_log[1], {1'b1, 8'h1F});
         chk("pace_third", we_log[2], {1'b0, 8'h07});
         chk("pace_addr_gap", (we_cyc[1] - we_cyc[0]) >= ADDR_GAP, 1);
         chk("pace_data_gap", (we_cyc[2] - we_cyc[1]) >= DATA_GAP, 1);
      end

      // Overflow: one data write starts the long gap, nine more arrive while pacing
      do_reset();
      we_cyc.delete(); we_log.delete();
      wr_pulse(16'h3FF5, 8'h30, 1'b1);
      for (int i = 1; i <= 9; i++) wr_pulse(16'h3FF5, 8'(8'h30 + i), 1'b1);
      chk("ovf_level", wq_level, WQ_DEPTH);
      chk("ovf_flag", wq_ovf, 1'b1);
      for (int i = 0; i < 1000 && we_log.size() < 9; i++)
         step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
      repeat (100) step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
      chk("ovf_out_count", we_log.size(), 9);
      if (we_log.size() == 9)
         for (int i = 1; i <= 8; i++)
            chk($sformatf("ovf_out%0d", i), we_log[i], {1'b1, 8'(8'h30 + i)});
      chk("ovf_sticky", wq_ovf, 1'b1);

      // Long wr strobe gives one push; reset mid-queue flushes everything
      do_reset();
      repeat (5) step(1'b1, 1'b1, 16'h3FF4, 8'h55, 1'b0);
      step(1'b1, 1'b0, 16'h3FF4, 8'h55, 1'b0);
      chk("hold_one_push", wq_level, 1);
      wr_pulse(16'h3FF5, 8'h66, 1'b0);
      wr_pulse(16'h3FF4, 8'h77, 1'b0);
      chk("level_three", wq_level, 3);
      reset = 1'b1;
      step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
      reset = 1'b0;
      chk("flush_level", wq_level, 0);
      chk("flush_we", opll_we, 1'b0);
      we_log.delete();
      repeat (30) step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
      chk("flush_no_strobe", we_log.size(), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int         sel;
         logic [15:0] ra;
         sel = $urandom_range(0, 9);
         case (sel)
            0: ra = 16'h3FF4;
            1: ra = 16'h3FF5;
            2: ra = 16'h3FF6;
            3: ra = 16'h3FF7;
            4: ra = 16'h1FFE;
            5: ra = 16'h1FFF;
            6: ra = 16'(($urandom_range(0, 16'h1FFF)));
            7: ra = 16'($urandom);
            8: ra = {15'h003E, 1'($urandom_range(0, 1))};
            default: ra = 16'(16'h2000 + $urandom_range(0, 16'h1FFF));
         endcase
         if (sel != 8) ra[15:14] = 2'($urandom_range(0, 3));
         iorq  = ($urandom_range(0, 3) == 0);
         m1    = ($urandom_range(0, 1) == 0);
         reset = ($urandom_range(0, 299) == 0);
         step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, ra,
              8'($urandom), $urandom_range(0, 1) == 1);
      end
      reset = 1'b0;
      iorq  = 1'b0;
      m1    = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
